// File: rtl/uart_tx_io.sv
// rtl/uart_tx_io.sv - FIFO-buffered UART transmitter; define UART_TX_PARITY_EN for an even-parity bit
module uart_tx_io #(
    parameter int DIVISOR = 868,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   RSTN,
    input  logic                   EN,
    input  logic [31:0]            P_Data,
    output logic                   tx,
    output logic                   busy,
    output logic                   fifo_full,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   tx_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   RELOAD   = 16'(DIVISOR - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ovf_q, ovf_d;
    logic            full_q, full_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic [7:0]      mem [DEPTH];
    logic            wr, clr, push, pop, bit_end;
    logic [7:0]      head;
    logic            unused_pdata;

    assign unused_pdata = ^P_Data[30:8];

    always_comb begin
        wr      = EN && !P_Data[31];
        clr     = EN && P_Data[31];
        head    = mem[rptr_q];
        bit_end = (cnt_q == 16'd0);
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: pop = (count_q != '0);
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = RELOAD;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = RELOAD;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = RELOAD;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // A pop always starts a frame, whether from IDLE or straight out of STOP
        if (pop) begin
            state_d = START;
            cnt_d   = RELOAD;
            shift_d = head;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
        end

        push    = wr && (!full_q || pop);
        count_d = count_q + CW'(push) - CW'(pop);
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        full_d  = (count_d == FULL_CNT);
        ovf_d   = clr ? 1'b0 : ((wr && !push) ? 1'b1 : ovf_q);
        busy_d  = (state_d != IDLE) || (count_d != '0);
        done_d  = (state_d == STOP) && (cnt_d == 16'd0);
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            full_q  <= 1'b0;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            full_q  <= full_d;
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= P_Data[7:0];
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_full  = full_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign tx_done    = done_q;
endmodule

// File: doc/uart_tx_io.md
UART_TX_IO -- requirements
Module: uart_tx_io

Interface
REQ-001 Parameter DIVISOR, default 868, SHALL set clocks per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter DEPTH, default 8, SHALL set TX FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 RSTN  input  1  reset, asynchronous assert, active-low.
REQ-005 EN  input  1  bus write strobe for this peripheral (one cycle per write).
REQ-006 P_Data  input  32  CPU-to-IO write data; [7:0] byte, [31] clear-overflow command.
REQ-007 tx  output  1  serial line, idle high.
REQ-008 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-009 fifo_full  output  1  FIFO holds DEPTH entries.
REQ-010 fifo_count  output  log2(DEPTH)+1  number of FIFO entries.
REQ-011 overflow  output  1  sticky: a byte was dropped.
REQ-012 tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-013 EN=1 with P_Data[31]=0 SHALL push P_Data[7:0] at that clock edge if not full; if full, the byte SHALL be dropped and overflow set.
REQ-014 EN=1 with P_Data[31]=1 SHALL clear overflow and SHALL NOT push.
REQ-015 Simultaneous push and pop SHALL both succeed, even when full (count unchanged, byte accepted).
REQ-016 States IDLE, START, DATA, STOP (plus PARITY per REQ-027); IDLE with FIFO non-empty SHALL pop the head into the shift register and enter START at the same edge.
REQ-017 A write to an idle, empty block in cycle N SHALL drive tx low starting cycle N+2.
REQ-018 Every bit SHALL last exactly DIVISOR cycles, timed by a down-counter reloaded with DIVISOR-1 at each bit start.
REQ-019 DATA SHALL send 8 bits LSB first; a 3-bit index SHALL advance STOP after bit 7.
REQ-020 STOP SHALL drive tx high; at its final cycle tx_done pulses, and if the FIFO is non-empty the next pop SHALL occur at that edge so START follows with zero idle cycles; otherwise return to IDLE.
REQ-021 fifo_count/fifo_full SHALL reflect the registered FIFO state (update the cycle after the edge).
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-023 RSTN low SHALL immediately force tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0, tx_done=0, state IDLE.
REQ-024 Reset mid-frame SHALL abort the frame and discard all FIFO contents; no partial frame resumes after release.
REQ-025 First write SHALL be accepted on the first edge after RSTN deasserts.

Configuration
REQ-026 Macro UART_TX_PARITY_EN SHALL select parity support.
REQ-027 Defined: a PARITY state between DATA and STOP SHALL send even parity (XOR of the 8 data bits) for DIVISOR cycles; frame = 11 bits.
REQ-028 Undefined: no PARITY state or logic; frame = 10 bits.

Verification (DIVISOR=4, DEPTH=8, parity off unless stated)
REQ-029 Reset release, write 0x55 in cycle 0 -> tx low cycles 2-5, then 1,0,1,0,1,0,1,0 each 4 cycles, high stop cycles 38-41, tx_done at cycle 41, busy low from cycle 42.
REQ-030 Write 0x01 then 0x80 on consecutive cycles -> two frames back-to-back, second START immediately after first stop, no idle gap.
REQ-031 Ten writes on consecutive cycles from idle -> first nine accepted (one in shifter, eight in FIFO), fifo_full=1, tenth dropped, overflow=1; write 0x80000000 -> overflow=0, fifo_count unchanged.
REQ-032 Assert RSTN low during DATA bit 3 of a frame with 5 bytes queued -> tx=1 and fifo_count=0 immediately; after release, no frame starts until a new write.
REQ-033 UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1 after bit 7, stop bit at cycles 42-45, tx_done at cycle 45.
REQ-034 FIFO full with frame ending: push coinciding with STOP-end pop -> byte accepted, fifo_count stays 8, overflow stays 0.
